// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: merges WB-stage writes and buffered MDU results onto one RF write port.
// Optional starvation-forced MDU writes are enabled by defining RF_ARB_FAIRNESS_EN.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  output logic        pipe_ready,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [63:0] pipe_wdata,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [63:0] mdu_wdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [31:0] busy_vec
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH == 0 || STARVE_LIMIT == 0) begin : g_bad_cfg
    $error("rf_wb_arbiter: FIFO_DEPTH and STARVE_LIMIT must be nonzero");
  end

  logic [4:0]    rd_mem_q   [FIFO_DEPTH];
  logic [63:0]   data_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   busy_q, busy_d;
  logic          wen_q;
  logic [4:0]    waddr_q;
  logic [63:0]   wdata_q;

  logic        head_valid, pipe_need, forced, grant_head, push, pop, wen_d;
  logic [4:0]  head_rd;
  logic [63:0] head_data;

  assign head_valid = (cnt_q != '0);
  assign head_rd    = rd_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];
  assign pipe_need  = pipe_valid && pipe_wen && (pipe_rd != '0);
  assign mdu_ready  = (cnt_q != CW'(FIFO_DEPTH));

  // On a same-rd conflict the MDU result is younger, so the head wins and the pipe beat is dropped.
  assign grant_head = head_valid && (!pipe_need || forced || (head_rd == pipe_rd));
  assign wen_d      = grant_head || pipe_need;
  assign push       = mdu_valid && mdu_ready;
  assign pop        = grant_head;

`ifdef RF_ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign forced     = head_valid && (starve_q == SW'(STARVE_LIMIT));
  assign pipe_ready = !(forced && pipe_need);

  always_comb begin
    starve_d = '0;
    if (head_valid && !grant_head) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign forced     = 1'b0;
  assign pipe_ready = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    busy_d = busy_q;
    if (grant_head) busy_d[head_rd] = 1'b0;
    if (mdu_issue && (mdu_issue_rd != '0)) busy_d[mdu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      wen_q  <= wen_d;
      if (wen_d) begin
        waddr_q <= grant_head ? head_rd   : pipe_rd;
        wdata_q <= grant_head ? head_data : pipe_wdata;
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= mdu_rd;
      data_mem_q[wr_ptr_q] <= mdu_wdata;
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then random traffic against a queue model.
module tb_rf_wb_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 2;
`ifdef RF_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_ready, pipe_wen;
  logic [4:0]  pipe_rd;
  logic [63:0] pipe_wdata;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy_vec;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wen(pipe_wen),
    .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [63:0] d; } entry_t;
  entry_t      q[$];
  int unsigned starve;
  logic        exp_wen;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata;
  logic [31:0] exp_busy;
  bit          last_pipe_ready;

  int n_checks = 0;
  int fails    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve    = 0;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_busy  = '0;
  endtask

  task automatic idle();
    pipe_valid = 0; pipe_wen = 0; pipe_rd = '0; pipe_wdata = '0;
    mdu_issue = 0; mdu_issue_rd = '0; mdu_valid = 0; mdu_rd = '0; mdu_wdata = '0;
  endtask

  // One clock: check handshakes, advance the model, check the registered outputs.
  task automatic step();
    bit     head_v, need, forced, ghead;
    entry_t h;
    int unsigned n;
    #1;
    n      = q.size();
    head_v = (n > 0);
    need   = pipe_valid && pipe_wen && (pipe_rd != 0);
    forced = FAIR && head_v && (starve == LIMIT);
    ghead  = head_v && (!need || forced || (q[0].rd == pipe_rd));
    last_pipe_ready = !(forced && need);
    check("mdu_ready", {63'd0, mdu_ready}, {63'd0, n < DEPTH});
    check("pipe_ready", {63'd0, pipe_ready}, {63'd0, last_pipe_ready});
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      if (ghead) begin
        h = q.pop_front();
        exp_wen = 1; exp_waddr = h.rd; exp_wdata = h.d;
        exp_busy[h.rd] = 1'b0;
        starve = 0;
      end else if (need) begin
        exp_wen = 1; exp_waddr = pipe_rd; exp_wdata = pipe_wdata;
        starve = head_v ? starve + 1 : 0;
      end else begin
        exp_wen = 0;
        starve = 0;
      end
      if (mdu_issue && mdu_issue_rd != 0) exp_busy[mdu_issue_rd] = 1'b1;
      exp_busy[0] = 1'b0;
      if (mdu_valid && n < DEPTH) q.push_back('{rd: mdu_rd, d: mdu_wdata});
    end
    check("rf_wen", {63'd0, rf_wen}, {63'd0, exp_wen});
    if (exp_wen) begin
      check("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_waddr});
      check("rf_wdata", rf_wdata, exp_wdata);
    end
    check("busy_vec", {32'd0, busy_vec}, {32'd0, exp_busy});
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_rf_wen", {63'd0, rf_wen}, 64'd0);
    check("reset_rf_waddr", {59'd0, rf_waddr}, 64'd0);
    check("reset_rf_wdata", rf_wdata, 64'd0);
    check("reset_busy", {32'd0, busy_vec}, 64'd0);
    rst = 0;

    // Plain pipe write to x5
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 5; pipe_wdata = 64'h1234;
    step();
    check("pipe_w_addr", {59'd0, rf_waddr}, 64'd5);
    check("pipe_w_data", rf_wdata, 64'h1234);
    check("pipe_w_ready", {63'd0, last_pipe_ready}, 64'd1);
    idle(); step();

    // MDU issue then result for x7
    mdu_issue = 1; mdu_issue_rd = 7; step();
    check("busy7_set", {63'd0, busy_vec[7]}, 64'd1);
    idle(); mdu_valid = 1; mdu_rd = 7; mdu_wdata = 64'hAA; step();
    idle(); step();
    check("mdu_w_wen", {63'd0, rf_wen}, 64'd1);
    check("mdu_w_addr", {59'd0, rf_waddr}, 64'd7);
    check("mdu_w_data", rf_wdata, 64'hAA);
    check("busy7_clr", {63'd0, busy_vec[7]}, 64'd0);

    // Same-rd conflict: head wins, pipe beat accepted and dropped
    idle(); mdu_valid = 1; mdu_rd = 9; mdu_wdata = 64'h2; step();
    idle(); pipe_valid = 1; pipe_wen = 1; pipe_rd = 9; pipe_wdata = 64'h1; step();
    check("conf_ready", {63'd0, last_pipe_ready}, 64'd1);
    check("conf_data", rf_wdata, 64'h2);
    idle(); step();
    check("conf_no_pipe_w", {63'd0, rf_wen}, 64'd0);

    // Non-writing pipe beat alongside FIFO head x3
    idle(); mdu_valid = 1; mdu_rd = 3; mdu_wdata = 64'h33; step();
    idle(); pipe_valid = 1; pipe_wen = 0; pipe_rd = 3; step();
    check("nowen_ready", {63'd0, last_pipe_ready}, 64'd1);
    check("nowen_addr", {59'd0, rf_waddr}, 64'd3);
    check("nowen_data", rf_wdata, 64'h33);

    // Starvation under continuous pipe writes
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle();
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 1; pipe_wdata = 64'(c);
      mdu_valid = (c < 4); mdu_rd = 5'(10 + c); mdu_wdata = 64'(16'hB00 + c);
      step();
      if (c == 2) check("full_mdu_ready", {63'd0, mdu_ready}, 64'd0);
      if (c == 4) check("starve_pre", {63'd0, last_pipe_ready}, 64'd1);
      if (c == 5) begin
        check("starve_force_ready", {63'd0, last_pipe_ready}, FAIR ? 64'd0 : 64'd1);
        check("starve_force_addr", {59'd0, rf_waddr}, FAIR ? 64'd10 : 64'd1);
      end
    end

    // Reset with a full FIFO and busy bits 3 and 7
    do_reset();
    idle(); pipe_valid = 1; pipe_wen = 1; pipe_rd = 1;
    mdu_issue = 1; mdu_issue_rd = 3; mdu_valid = 1; mdu_rd = 20; step();
    mdu_issue_rd = 7; mdu_rd = 21; step();
    check("busy_88", {32'd0, busy_vec}, 64'h88);
    do_reset();
    check("rst_busy", {32'd0, busy_vec}, 64'd0);
    check("rst_wen", {63'd0, rf_wen}, 64'd0);
    idle(); step();
    check("rst_empty_wen", {63'd0, rf_wen}, 64'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      pipe_valid   = $urandom_range(0, 3) != 0;
      pipe_wen     = $urandom_range(0, 3) != 0;
      pipe_rd      = 5'($urandom_range(0, 7));
      pipe_wdata   = {$urandom, $urandom};
      mdu_issue    = $urandom_range(0, 2) == 0;
      mdu_issue_rd = 5'($urandom_range(0, 31));
      mdu_valid    = $urandom_range(0, 2) == 0;
      mdu_rd       = 5'($urandom_range(0, 7));
      mdu_wdata    = {$urandom, $urandom};
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, fails);
    $finish;
  end

endmodule
